// File: rtl/fir_l3_pkg.sv
// Shared types and the rescale helper for the L3 FIR output serializer.
// Samples are signed Q-format values reduced to the system sample width.
package fir_l3_pkg;

  localparam int DIN_W     = 64;
  localparam int DOUT_W    = 16;
  localparam int SHIFT_DEF = 30;

  typedef logic signed [DOUT_W-1:0] smp_t;
  typedef smp_t [0:2] blk_t;

  typedef struct packed {
    logic sat;
    smp_t smp;
  } rs_t;

  localparam logic signed [DIN_W:0] MAXV =
    {{(DIN_W-DOUT_W+2){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DIN_W:0] MINV = ~MAXV;

  // One guard bit above the input keeps the rounding add from wrapping.
  function automatic rs_t round_sat(
    input logic signed [DIN_W-1:0] y,
    input int                      shift
  );
    logic signed [DIN_W:0] rnd;
    logic signed [DIN_W:0] w;
    rs_t r;
    rnd = {{DIN_W{1'b0}}, 1'b1} << (shift - 1);
    w = ($signed({y[DIN_W-1], y}) + rnd) >>> shift;
    r.sat = 1'b0;
    r.smp = w[DOUT_W-1:0];
    if (w > MAXV) begin
      r.sat = 1'b1;
      r.smp = MAXV[DOUT_W-1:0];
    end else if (w < MINV) begin
      r.sat = 1'b1;
      r.smp = MINV[DOUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_l3_serializer_fifo.sv
// Block FIFO holding scaled 3-sample blocks; count kept beside the pointers.
// A push while full is dropped here unless a pop frees the slot the same cycle.
module fir_blk_fifo
  import fir_l3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  blk_t                       din,
  output blk_t                       head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  blk_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_l3_serializer.sv
// Captures L3 FIR output blocks, rescales them with rounding/saturation,
// buffers them and streams one sample per valid/ready transfer.
module fir_l3_serializer
  import fir_l3_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DIN_W,
  parameter int DATA_OUT_WIDTH = DOUT_W,
  parameter int SHIFT          = SHIFT_DEF,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             blk_valid_i,
  input  logic [DATA_IN_WIDTH-1:0]         y0_i,
  input  logic [DATA_IN_WIDTH-1:0]         y1_i,
  input  logic [DATA_IN_WIDTH-1:0]         y2_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_OUT_WIDTH-1:0]        out_data_o,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count_o,
  output logic                             overflow_o,
  output logic                             sat_o
);

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  rs_t        r0, r1, r2;
  blk_t       scaled;
  blk_t       stage_blk;
  blk_t       head;
  logic       stage_valid;
  logic [1:0] phase;
  logic       xfer;
  logic       pop;
  logic       full;
  logic       empty;

  always_comb begin
    r0 = round_sat(y0_i, SHIFT);
    r1 = round_sat(y1_i, SHIFT);
    r2 = round_sat(y2_i, SHIFT);
    scaled = {r0.smp, r1.smp, r2.smp};
  end

  assign out_valid_o = ~empty;
  assign xfer        = out_valid_o & out_ready_i;
  assign pop         = xfer & (phase == PH2);

  fir_blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (stage_valid),
    .pop     (pop),
    .din     (stage_blk),
    .head    (head),
    .count   (fifo_count_o),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_blk   <= '0;
      sat_o       <= 1'b0;
      phase       <= PH0;
      overflow_o  <= 1'b0;
    end else begin
      stage_valid <= blk_valid_i;
      stage_blk   <= scaled;
      sat_o       <= blk_valid_i & (r0.sat | r1.sat | r2.sat);
      if (xfer) phase <= (phase == PH2) ? PH0 : phase + 1'b1;
      if (stage_valid & full & ~pop) overflow_o <= 1'b1;
    end
  end

  always_comb begin
    out_data_o = '0;
    if (out_valid_o) begin
      unique case (1'b1)
        phase == PH0: out_data_o = head[0];
        phase == PH1: out_data_o = head[1];
        phase == PH2: out_data_o = head[2];
        default:      out_data_o = '0;
      endcase
    end
  end

endmodule

// File: doc/fir_l3_serializer.md
Name: fir_l3_serializer

Overview:
Downstream stage of the 3-parallel (L3) reduced-complexity FIR. It captures each 3-sample output block (y0, y1, y2 = data_out_1..3, one block per clk) and rescales each 64-bit accumulator to the system sample width with rounding and saturation. Blocks are held in a small block FIFO. They are emitted as a single serial sample stream, one sample per accepted transfer, under a valid/ready handshake. This turns the 3-wide block-rate output into the 1-wide stream consumed by the DAC/packetiser side.

Parameters:
DATA_IN_WIDTH, 64, width of each filter output word (signed).
DATA_OUT_WIDTH, 16, width of each serial output sample (signed).
SHIFT, 30, arithmetic right shift applied for Q-format rescale (tap fraction bits); must be >=1.
FIFO_DEPTH, 4, block FIFO depth in 3-sample blocks; power of 2, >=2.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
blk_valid_i  in  1  y0_i..y2_i carry a valid block this cycle
y0_i  in  DATA_IN_WIDTH  signed block sample 0 (oldest, emitted first)
y1_i  in  DATA_IN_WIDTH  signed block sample 1
y2_i  in  DATA_IN_WIDTH  signed block sample 2 (newest)
out_valid_o  out  1  out_data_o valid
out_ready_i  in  1  consumer accepts sample
out_data_o  out  DATA_OUT_WIDTH  signed serial sample
fifo_count_o  out  clog2(FIFO_DEPTH)+1  blocks stored in FIFO
overflow_o  out  1  sticky: a block was dropped
sat_o  out  1  one-cycle pulse: staged block had >=1 saturated sample

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0. FIFO empty, phase=0, stage register invalid, overflow_o=0.
- Stage 1, scale register:
  - On every edge, stage_valid <= blk_valid_i.
  - Each yk is computed as s = (yk + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up, computed at DATA_IN_WIDTH+1 bits so it cannot wrap.
  - s is clamped to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
  - sat_o <= blk_valid_i & (any sample clamped).
- Stage 2, FIFO write:
  - If stage_valid and (count<FIFO_DEPTH or a pop occurs this cycle), push the 3 scaled samples as one entry.
  - If stage_valid and full with no pop this cycle, drop the block and set overflow_o=1 (cleared only by reset).
- Output:
  - out_valid_o = (count!=0).
  - out_data_o = head[phase] when valid, else 0. This is combinational from FIFO head and phase.
  - On out_valid_o & out_ready_i, phase advances 0->1->2. On the phase-2 handshake, phase returns to 0 and the head block pops.
  - When out_ready_i is held 1, the output sequence is gapless while the FIFO is non-empty.
- Latency: blk_valid_i high in cycle N gives out_valid_o high in cycle N+2 (FIFO previously empty).
- Simultaneous push+pop: count unchanged; the write pointer and read pointer each advance.
- Pointer wrap: pointers are clog2(FIFO_DEPTH) bits and wrap naturally. count is tracked separately and is never above FIFO_DEPTH.
- out_valid_o/out_data_o are stable while out_valid_o=1 and out_ready_i=0.
- Throughput: sustained blk_valid_i every cycle overflows unless the consumer is fed through a 3x clock. Block spacing >=3 cycles with out_ready_i=1 never overflows.

Decomposition:
- Package fir_l3_pkg:
  - widths DATA_IN_WIDTH/DATA_OUT_WIDTH/SHIFT defaults
  - typedef blk_t (array [0:2] of signed DATA_OUT_WIDTH)
  - function round_sat(logic signed [DATA_IN_WIDTH-1:0]) returning sample + sat flag
- Sub-module fir_blk_fifo: synchronous FIFO of blk_t with push/pop/count/full/empty. Push while full is ignored internally; the overflow decision stays in the parent.

Test Plan:
- Rounding: SHIFT=30, one block y0=3*2^30, y1=2^29, y2=-(2^29), out_ready=1 -> serial 3, 1, 0. out_valid first high 2 cycles after blk_valid; sat_o=0.
- Saturation: y0=2^50, y1=-(2^50), y2=32767*2^30 -> 32767, -32768, 32767. sat_o pulses exactly 1 cycle, 1 cycle after blk_valid.
- Overflow: out_ready=0, 6 consecutive blocks (values 1..18 after scaling) -> fifo_count=4, overflow_o=1. Releasing ready yields 1..12 in order, gapless, then out_valid=0.
- Backpressure: toggle out_ready every cycle over 2 blocks -> 6 samples in order, no duplicate/skip, out_data stable while stalled.
- Push at full with pop: FIFO full, ready=1 at phase 2 same cycle a staged block arrives -> block accepted, count stays 4, overflow_o stays 0.
- Reset mid-stream: assert reset_n=0 while phase=1 with 3 blocks stored -> all outputs 0 immediately. After release, a new block is emitted from phase 0 with no stale samples.
